// File: rtl/swc_wb_port_bridge.sv
// Per-port pipelined Wishbone register slice with 2-entry skid buffers, registered
// stall/return paths and saturating frame/word statistics counters.
module swc_wb_port_bridge #(
  parameter int g_num_ports  = 7,
  parameter int g_data_width = 16,
  parameter int g_addr_width = 2,
  parameter int g_sel_width  = 2,
  parameter int g_cnt_width  = 32
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [g_num_ports*g_data_width-1:0] snk_dat_i,
  input  logic [g_num_ports*g_addr_width-1:0] snk_adr_i,
  input  logic [g_num_ports*g_sel_width-1:0]  snk_sel_i,
  input  logic [g_num_ports-1:0]              snk_cyc_i,
  input  logic [g_num_ports-1:0]              snk_stb_i,
  input  logic [g_num_ports-1:0]              snk_we_i,
  output logic [g_num_ports-1:0]              snk_stall_o,
  output logic [g_num_ports-1:0]              snk_ack_o,
  output logic [g_num_ports-1:0]              snk_err_o,
  output logic [g_num_ports-1:0]              snk_rty_o,
  output logic [g_num_ports*g_data_width-1:0] src_dat_o,
  output logic [g_num_ports*g_addr_width-1:0] src_adr_o,
  output logic [g_num_ports*g_sel_width-1:0]  src_sel_o,
  output logic [g_num_ports-1:0]              src_cyc_o,
  output logic [g_num_ports-1:0]              src_stb_o,
  output logic [g_num_ports-1:0]              src_we_o,
  input  logic [g_num_ports-1:0]              src_stall_i,
  input  logic [g_num_ports-1:0]              src_ack_i,
  input  logic [g_num_ports-1:0]              src_err_i,
  input  logic [g_num_ports-1:0]              src_rty_i,
  input  logic [g_num_ports-1:0]              cnt_clr_i,
  output logic [g_num_ports*g_cnt_width-1:0]  frame_cnt_o,
  output logic [g_num_ports*g_cnt_width-1:0]  word_cnt_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Payload packing: {we, sel, adr, dat}
  localparam int c_pw = 1 + g_sel_width + g_addr_width + g_data_width;
  localparam logic [g_cnt_width-1:0] c_cnt_max = {g_cnt_width{1'b1}};
  localparam logic [g_cnt_width-1:0] c_cnt_one = {{(g_cnt_width-1){1'b0}}, 1'b1};

  for (genvar p = 0; p < g_num_ports; p++) begin : g_port
    state_t                 state_r;
    state_t                 state_next_s;
    logic [c_pw-1:0]        in_pl_s;
    logic [c_pw-1:0]        out_pl_r;
    logic [c_pw-1:0]        skd_pl_r;
    logic [c_pw-1:0]        out_pl_next_s;
    logic [c_pw-1:0]        skd_pl_next_s;
    logic                   accept_s;
    logic                   move_s;
    logic                   cyc_fall_s;
    logic                   stall_r;
    logic                   cyc_r;
    logic                   stb_r;
    logic                   ack_r;
    logic                   err_r;
    logic                   rty_r;
    logic                   cyc_prev_r;
    logic [g_cnt_width-1:0] word_cnt_r;
    logic [g_cnt_width-1:0] frame_cnt_r;

    assign in_pl_s = {snk_we_i[p],
                      snk_sel_i[p*g_sel_width +: g_sel_width],
                      snk_adr_i[p*g_addr_width +: g_addr_width],
                      snk_dat_i[p*g_data_width +: g_data_width]};

    assign accept_s   = snk_cyc_i[p] & snk_stb_i[p] & ~stall_r;
    assign move_s     = (state_r != ST_EMPTY) & ~src_stall_i[p];
    assign cyc_fall_s = cyc_prev_r & ~snk_cyc_i[p];

    // Skid-buffer next state and payload steering
    always_comb begin
      state_next_s  = state_r;
      out_pl_next_s = out_pl_r;
      skd_pl_next_s = skd_pl_r;
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_next_s  = ST_ONE;
            out_pl_next_s = in_pl_s;
          end else begin
            state_next_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && move_s) begin
            state_next_s  = ST_ONE;
            out_pl_next_s = in_pl_s;
          end else if (accept_s) begin
            state_next_s  = ST_FULL;
            skd_pl_next_s = in_pl_s;
          end else if (move_s) begin
            state_next_s = ST_EMPTY;
          end else begin
            state_next_s = ST_ONE;
          end
        end
        ST_FULL: begin
          if (move_s) begin
            state_next_s  = ST_ONE;
            out_pl_next_s = skd_pl_r;
          end else begin
            state_next_s = ST_FULL;
          end
        end
        default: begin
          state_next_s = ST_EMPTY;
        end
      endcase
    end

    // Buffer state, registered control outputs and one-cycle return path
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_r  <= ST_EMPTY;
        out_pl_r <= '0;
        skd_pl_r <= '0;
        stall_r  <= 1'b0;
        cyc_r    <= 1'b0;
        stb_r    <= 1'b0;
        ack_r    <= 1'b0;
        err_r    <= 1'b0;
        rty_r    <= 1'b0;
      end else begin
        state_r  <= state_next_s;
        out_pl_r <= out_pl_next_s;
        skd_pl_r <= skd_pl_next_s;
        stall_r  <= (state_next_s == ST_FULL);
        cyc_r    <= snk_cyc_i[p] | (state_next_s != ST_EMPTY);
        stb_r    <= (state_next_s != ST_EMPTY);
        // Responses arriving while the downstream cycle is idle are dropped
        ack_r    <= src_ack_i[p] & cyc_r;
        err_r    <= src_err_i[p] & cyc_r;
        rty_r    <= src_rty_i[p] & cyc_r;
      end
    end

    // Saturating statistics counters; clear wins over a same-cycle increment
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cyc_prev_r  <= 1'b0;
        word_cnt_r  <= '0;
        frame_cnt_r <= '0;
      end else begin
        cyc_prev_r <= snk_cyc_i[p];
        if (cnt_clr_i[p]) begin
          word_cnt_r  <= '0;
          frame_cnt_r <= '0;
        end else begin
          if (accept_s && (word_cnt_r != c_cnt_max)) begin
            word_cnt_r <= word_cnt_r + c_cnt_one;
          end else begin
            word_cnt_r <= word_cnt_r;
          end
          if (cyc_fall_s && (frame_cnt_r != c_cnt_max)) begin
            frame_cnt_r <= frame_cnt_r + c_cnt_one;
          end else begin
            frame_cnt_r <= frame_cnt_r;
          end
        end
      end
    end

    assign snk_stall_o[p] = stall_r;
    assign snk_ack_o[p]   = ack_r;
    assign snk_err_o[p]   = err_r;
    assign snk_rty_o[p]   = rty_r;
    assign src_cyc_o[p]   = cyc_r;
    assign src_stb_o[p]   = stb_r;
    assign src_we_o[p]    = out_pl_r[c_pw-1];
    assign src_sel_o[p*g_sel_width +: g_sel_width] =
      out_pl_r[g_addr_width+g_data_width +: g_sel_width];
    assign src_adr_o[p*g_addr_width +: g_addr_width] =
      out_pl_r[g_data_width +: g_addr_width];
    assign src_dat_o[p*g_data_width +: g_data_width] = out_pl_r[g_data_width-1:0];
    assign word_cnt_o[p*g_cnt_width +: g_cnt_width]  = word_cnt_r;
    assign frame_cnt_o[p*g_cnt_width +: g_cnt_width] = frame_cnt_r;
  end

endmodule

// File: tb/tb_swc_wb_port_bridge.sv
// Scoreboard bench for swc_wb_port_bridge: directed per-port scenarios, a random
// stall soak on port 1, and a narrow-counter instance for saturation/clear.
module tb_swc_wb_port_bridge;
  localparam int N  = 7;
  localparam int DW = 16;
  localparam int AW = 2;
  localparam int SW = 2;
  localparam int CW = 32;
  localparam int PW = 1 + SW + AW + DW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N*DW-1:0] snk_dat, src_dat;
  logic [N*AW-1:0] snk_adr, src_adr;
  logic [N*SW-1:0] snk_sel, src_sel;
  logic [N-1:0] snk_cyc, snk_stb, snk_we, snk_stall, snk_ack, snk_err, snk_rty;
  logic [N-1:0] src_cyc, src_stb, src_we, src_stall, src_ack, src_err, src_rty, cnt_clr;
  logic [N*CW-1:0] frame_cnt, word_cnt;

  // Narrow-counter single-port instance
  logic [DW-1:0] s_snk_dat, s_src_dat;
  logic [AW-1:0] s_snk_adr, s_src_adr;
  logic [SW-1:0] s_snk_sel, s_src_sel;
  logic s_snk_cyc, s_snk_stb, s_snk_we, s_snk_stall, s_snk_ack, s_snk_err, s_snk_rty;
  logic s_src_cyc, s_src_stb, s_src_we, s_src_stall, s_src_ack, s_src_err, s_src_rty, s_clr;
  logic [3:0] s_frame_cnt, s_word_cnt;

  swc_wb_port_bridge dut (
    .clk_i(clk), .rst_i(rst),
    .snk_dat_i(snk_dat), .snk_adr_i(snk_adr), .snk_sel_i(snk_sel),
    .snk_cyc_i(snk_cyc), .snk_stb_i(snk_stb), .snk_we_i(snk_we),
    .snk_stall_o(snk_stall), .snk_ack_o(snk_ack), .snk_err_o(snk_err), .snk_rty_o(snk_rty),
    .src_dat_o(src_dat), .src_adr_o(src_adr), .src_sel_o(src_sel),
    .src_cyc_o(src_cyc), .src_stb_o(src_stb), .src_we_o(src_we),
    .src_stall_i(src_stall), .src_ack_i(src_ack), .src_err_i(src_err), .src_rty_i(src_rty),
    .cnt_clr_i(cnt_clr), .frame_cnt_o(frame_cnt), .word_cnt_o(word_cnt)
  );

  swc_wb_port_bridge #(.g_num_ports(1), .g_cnt_width(4)) dut_sat (
    .clk_i(clk), .rst_i(rst),
    .snk_dat_i(s_snk_dat), .snk_adr_i(s_snk_adr), .snk_sel_i(s_snk_sel),
    .snk_cyc_i(s_snk_cyc), .snk_stb_i(s_snk_stb), .snk_we_i(s_snk_we),
    .snk_stall_o(s_snk_stall), .snk_ack_o(s_snk_ack), .snk_err_o(s_snk_err), .snk_rty_o(s_snk_rty),
    .src_dat_o(s_src_dat), .src_adr_o(s_src_adr), .src_sel_o(s_src_sel),
    .src_cyc_o(s_src_cyc), .src_stb_o(s_src_stb), .src_we_o(s_src_we),
    .src_stall_i(s_src_stall), .src_ack_i(s_src_ack), .src_err_i(s_src_err), .src_rty_i(s_src_rty),
    .cnt_clr_i(s_clr), .frame_cnt_o(s_frame_cnt), .word_cnt_o(s_word_cnt)
  );

  int checks = 0;
  int errors = 0;
  int ack_cnt1 = 0;

  typedef struct {
    int             port;
    logic [PW-1:0]  pl;
  } sb_t;
  sb_t sb_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] snk_pl(input int p);
    return {snk_we[p], snk_sel[p*SW +: SW], snk_adr[p*AW +: AW], snk_dat[p*DW +: DW]};
  endfunction

  function automatic logic [PW-1:0] src_pl(input int p);
    return {src_we[p], src_sel[p*SW +: SW], src_adr[p*AW +: AW], src_dat[p*DW +: DW]};
  endfunction

  function automatic logic [CW-1:0] wcnt(input int p);
    return word_cnt[p*CW +: CW];
  endfunction

  function automatic logic [CW-1:0] fcnt(input int p);
    return frame_cnt[p*CW +: CW];
  endfunction

  task automatic set_word(input int p, input logic [15:0] d);
    snk_dat[p*DW +: DW] = d;
    snk_adr[p*AW +: AW] = d[1:0];
    snk_sel[p*SW +: SW] = d[5:4];
    snk_we[p]           = d[8];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: records accepted words, checks downstream order and the ack delay
  initial begin : monitor
    logic [N-1:0] ack_pend;
    logic [N-1:0] ack_exp;
    bit           found;
    ack_pend = '0;
    ack_exp  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb_q.delete();
        ack_pend = '0;
      end else begin
        for (int p = 0; p < N; p++) begin
          if (ack_pend[p]) chk($sformatf("ack_delay_p%0d", p), 64'(snk_ack[p]), 64'(ack_exp[p]));
          if (p == 1 && snk_ack[1]) ack_cnt1++;
          ack_exp[p]  = src_ack[p] & src_cyc[p];
          ack_pend[p] = 1'b1;
          if (src_stb[p] && !src_stall[p]) begin
            found = 1'b0;
            for (int i = 0; i < sb_q.size(); i++) begin
              if (sb_q[i].port == p) begin
                chk($sformatf("sb_order_p%0d", p), 64'(src_pl(p)), 64'(sb_q[i].pl));
                sb_q.delete(i);
                found = 1'b1;
                break;
              end
            end
            if (!found) chk($sformatf("sb_unexpected_p%0d", p), 64'd1, 64'd0);
          end
          if (snk_cyc[p] && snk_stb[p] && !snk_stall[p]) sb_q.push_back('{p, snk_pl(p)});
        end
      end
    end
  end

  initial begin : stim
    int  idx;
    int  ncyc;
    logic acc;
    logic xfer;
    rst = 1'b1;
    snk_dat = '0; snk_adr = '0; snk_sel = '0; snk_cyc = '0; snk_stb = '0; snk_we = '0;
    src_stall = '0; src_ack = '0; src_err = '0; src_rty = '0; cnt_clr = '0;
    s_snk_dat = '0; s_snk_adr = '0; s_snk_sel = '0; s_snk_cyc = 1'b0; s_snk_stb = 1'b0;
    s_snk_we = 1'b0; s_src_stall = 1'b0; s_src_ack = 1'b0; s_src_err = 1'b0;
    s_src_rty = 1'b0; s_clr = 1'b0;
    tick(); tick();
    chk("rst_stall", 64'(snk_stall), 64'd0);
    chk("rst_cyc_stb", 64'({src_cyc, src_stb}), 64'd0);
    chk("rst_cnt", 64'(|{word_cnt, frame_cnt}), 64'd0);
    rst = 1'b0;
    tick();

    // Port 0: four back-to-back words, no downstream stall
    snk_cyc[0] = 1'b1; snk_stb[0] = 1'b1;
    set_word(0, 16'h1111); tick();
    chk("p0_stb1", 64'(src_stb[0]), 64'd1); chk("p0_dat1", 64'(src_dat[15:0]), 64'h1111);
    set_word(0, 16'h2222); tick();
    chk("p0_dat2", 64'(src_dat[15:0]), 64'h2222);
    set_word(0, 16'h3333); tick();
    chk("p0_dat3", 64'(src_dat[15:0]), 64'h3333);
    set_word(0, 16'h4444); tick();
    chk("p0_dat4", 64'(src_dat[15:0]), 64'h4444); chk("p0_stall", 64'(snk_stall[0]), 64'd0);
    snk_stb[0] = 1'b0; tick();
    chk("p0_stb_off", 64'(src_stb[0]), 64'd0);
    snk_cyc[0] = 1'b0; tick();
    chk("p0_word_cnt", 64'(wcnt(0)), 64'd4);
    chk("p0_frame_cnt", 64'(fcnt(0)), 64'd1);
    chk("p0_cyc_off", 64'(src_cyc[0]), 64'd0);

    // Port 2: downstream stalled while three words are offered
    src_stall[2] = 1'b1; snk_cyc[2] = 1'b1; snk_stb[2] = 1'b1;
    set_word(2, 16'hA001); tick();
    chk("p2_stall_a", 64'(snk_stall[2]), 64'd0);
    set_word(2, 16'hA002); tick();
    chk("p2_stall_b", 64'(snk_stall[2]), 64'd1);
    set_word(2, 16'hA003); tick();
    chk("p2_hold_dat", 64'(src_dat[2*DW +: DW]), 64'hA001);
    chk("p2_hold_cnt", 64'(wcnt(2)), 64'd2);
    src_stall[2] = 1'b0; tick();
    chk("p2_dat_b", 64'(src_dat[2*DW +: DW]), 64'hA002); chk("p2_unstall", 64'(snk_stall[2]), 64'd0);
    tick();
    chk("p2_dat_c", 64'(src_dat[2*DW +: DW]), 64'hA003);
    snk_stb[2] = 1'b0; snk_cyc[2] = 1'b0; tick(); tick();
    chk("p2_word_cnt", 64'(wcnt(2)), 64'd3);

    // Port 4: upstream drops cyc while the buffer is full
    src_stall[4] = 1'b1; snk_cyc[4] = 1'b1; snk_stb[4] = 1'b1;
    set_word(4, 16'hB001); tick();
    set_word(4, 16'hB002); tick();
    snk_cyc[4] = 1'b0; snk_stb[4] = 1'b0; tick();
    chk("p4_cyc_hold", 64'(src_cyc[4]), 64'd1);
    src_stall[4] = 1'b0; tick();
    chk("p4_cyc_drain", 64'(src_cyc[4]), 64'd1); chk("p4_dat_b", 64'(src_dat[4*DW +: DW]), 64'hB002);
    tick();
    chk("p4_cyc_off", 64'(src_cyc[4]), 64'd0); chk("p4_frame_cnt", 64'(fcnt(4)), 64'd1);

    // Port 1: random stalls on both sides, acks one cycle after each transfer
    idx = 0; ncyc = 0; snk_cyc[1] = 1'b1;
    while (idx < 1000 && ncyc < 20000) begin
      snk_stb[1]   = 1'($urandom_range(0, 1));
      src_stall[1] = 1'($urandom_range(0, 1));
      set_word(1, 16'(idx * 37 + 5));
      acc  = snk_cyc[1] & snk_stb[1] & ~snk_stall[1];
      xfer = src_stb[1] & ~src_stall[1];
      tick(); ncyc++;
      src_ack[1] = xfer;
      if (acc) idx++;
    end
    chk("p1_budget", 64'(idx), 64'd1000);
    snk_stb[1] = 1'b0; src_stall[1] = 1'b0;
    repeat (6) begin
      xfer = src_stb[1] & ~src_stall[1];
      tick();
      src_ack[1] = xfer;
    end
    src_ack[1] = 1'b0; snk_cyc[1] = 1'b0; tick(); tick();
    chk("p1_word_cnt", 64'(wcnt(1)), 64'd1000);
    chk("p1_ack_cnt", 64'(ack_cnt1), 64'd1000);
    chk("p1_frame_cnt", 64'(fcnt(1)), 64'd1);

    // Narrow counters: saturation then clear beating a same-cycle accept
    s_snk_cyc = 1'b1; s_snk_stb = 1'b1;
    repeat (20) tick();
    chk("sat_word_cnt", 64'(s_word_cnt), 64'd15);
    s_clr = 1'b1; tick();
    chk("sat_clr", 64'(s_word_cnt), 64'd0);
    s_clr = 1'b0; tick();
    chk("sat_after_clr", 64'(s_word_cnt), 64'd1);
    s_snk_stb = 1'b0; s_snk_cyc = 1'b0; tick();

    // Port 3 full, then reset with a response pending
    src_stall[3] = 1'b1; snk_cyc[3] = 1'b1; snk_stb[3] = 1'b1;
    set_word(3, 16'hC001); tick();
    set_word(3, 16'hC002); tick();
    chk("p3_full", 64'(snk_stall[3]), 64'd1);
    rst = 1'b1; src_ack[3] = 1'b1; tick();
    chk("rst2_stall_ack", 64'({snk_stall, snk_ack, snk_err, snk_rty}), 64'd0);
    chk("rst2_src_ctl", 64'({src_cyc, src_stb, src_we}), 64'd0);
    chk("rst2_payload", 64'(|{src_dat, src_adr, src_sel}), 64'd0);
    chk("rst2_cnt", 64'(|{word_cnt, frame_cnt}), 64'd0);
    rst = 1'b0; snk_cyc[3] = 1'b0; snk_stb[3] = 1'b0; src_stall[3] = 1'b0;
    tick();
    chk("p3_ack_gated", 64'(snk_ack[3]), 64'd0);
    chk("p3_no_replay", 64'(src_stb[3]), 64'd0);
    src_ack[3] = 1'b0;

    // Port 6 traffic after reset
    snk_cyc[6] = 1'b1; snk_stb[6] = 1'b1;
    set_word(6, 16'h0BEE); tick();
    chk("p6_dat_a", 64'(src_dat[6*DW +: DW]), 64'h0BEE);
    set_word(6, 16'h0CAF); tick();
    chk("p6_dat_b", 64'(src_dat[6*DW +: DW]), 64'h0CAF);
    snk_stb[6] = 1'b0; snk_cyc[6] = 1'b0; tick(); tick();
    chk("p6_word_cnt", 64'(wcnt(6)), 64'd2);
    chk("p6_frame_cnt", 64'(fcnt(6)), 64'd1);
    chk("p3_word_cnt", 64'(wcnt(3)), 64'd0);

    tick();
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
